// File: rtl/seg7_reader.sv
// Seven-segment pattern reader: debounces a (possibly digit-multiplexed) segment
// bus and recovers one hex nibble per digit position once a pattern is stable.
module seg7_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segments_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic                    err_clear,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update_stb,
  output logic                    err
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0] sel_q;
  logic [6:0]            seg_q;
  logic [7:0]            cnt;
  logic                  committed;

  logic                  commit;
  logic                  sel_none;
  logic                  sel_onehot;
  logic                  legal;
  logic                  blank;
  logic [3:0]            value;
  logic                  err_set;
  logic                  changed;

  always_comb begin
    legal = 1'b1;
    value = '0;
    case (seg_q)
      7'h3F: value = 4'h0;
      7'h06: value = 4'h1;
      7'h5B: value = 4'h2;
      7'h4F: value = 4'h3;
      7'h66: value = 4'h4;
      7'h6D: value = 4'h5;
      7'h7D: value = 4'h6;
      7'h07: value = 4'h7;
      7'h7F: value = 4'h8;
      7'h67: value = 4'h9;
      7'h77: value = 4'hA;
      7'h7C: value = 4'hB;
      7'h39: value = 4'hC;
      7'h5E: value = 4'hD;
      7'h79: value = 4'hE;
      7'h71: value = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    blank      = (seg_q == 7'h00);
    sel_none   = (sel_q == '0);
    sel_onehot = !sel_none && ((sel_q & (sel_q - 1'b1)) == '0);
    commit     = (cnt == STABLE_MAX) && !committed;
    err_set    = commit && !sel_none && (!sel_onehot || (!legal && !blank));
    changed    = ({digit_sel, segments_in} != {sel_q, seg_q});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= '0;
      seg_q       <= '0;
      cnt         <= '0;
      committed   <= 1'b0;
      digits_out  <= '0;
      digit_valid <= '0;
      update_stb  <= 1'b0;
      err         <= 1'b0;
    end else begin
      sel_q <= digit_sel;
      seg_q <= segments_in;
      // A new sample starts a fresh episode even on the edge that commits the old one.
      if (changed) begin
        cnt       <= 8'd1;
        committed <= 1'b0;
      end else begin
        if (cnt < STABLE_MAX) cnt <= cnt + 8'd1;
        if (commit) committed <= 1'b1;
      end

      update_stb <= commit && sel_onehot;
      if (commit && sel_onehot) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (sel_q[i]) begin
            digit_valid[i] <= legal;
            if (legal)      digits_out[4*i +: 4] <= value;
            else if (blank) digits_out[4*i +: 4] <= 4'h0;
          end
        end
      end

      if (err_set)        err <= 1'b1;
      else if (err_clear) err <= 1'b0;
    end
  end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
Inverse of the team's hex-to-seven-segment decoder. Samples a seven-segment pattern bus, optionally multiplexed across several digits by a one-hot digit select. Waits until each pattern has been stable for a programmable number of cycles, then recovers the hex nibble per digit. Used as a loopback checker on the display outputs and for reading external 7-seg-driven devices.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (>=1)
STABLE_CYCLES, 3, consecutive identical samples required before commit (>=1, <=255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
segments_in  input  7  segment pattern, bit0=seg1(top), bit1=seg2(upper right), bit2=seg3(lower right), bit3=seg4(bottom), bit4=seg5(lower left), bit5=seg6(upper left), bit6=seg7(middle); 1 = lit
digit_sel  input  NUM_DIGITS  one-hot digit currently driven; all-zero = blanking interval
err_clear  input  1  clears sticky err
digits_out  output  4*NUM_DIGITS  recovered nibbles, digit i at [4i+3:4i]
digit_valid  output  NUM_DIGITS  bit i set when digit i holds a valid decoded hex value
update_stb  output  1  one-cycle pulse on every commit
err  output  1  sticky error flag

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port named reset. Reset (including mid-operation) clears digits_out, digit_valid, update_stb, err, the sample register, the stability counter and the committed flag. The first post-reset cycle behaves as if no sample has been taken yet.
- Sample stage: every edge, {digit_sel, segments_in} loads into the sample register. If the new value equals the held value, cnt <= min(cnt+1, STABLE_CYCLES); otherwise cnt <= 1 and committed <= 0.
- Commit condition: cnt == STABLE_CYCLES and committed == 0. On the following edge, the commit action below occurs and committed is set, so there is exactly one commit per stable episode.
- Latency: inputs first sampled at edge E0, held constant. Commit registers update at edge E(STABLE_CYCLES). update_stb is high for the single cycle after that edge.
- Commit action by the sampled digit_sel:
  - All-zero: no action. No update_stb, no err.
  - Multi-hot: no digit update, err <= 1, no update_stb.
  - One-hot, digit i:
    - Pattern is one of the 16 legal codes: nibble i <= value, digit_valid[i] <= 1, update_stb pulses. Legal codes (7654321 order): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001.
    - Pattern 0000000 (blank): nibble i <= 0, digit_valid[i] <= 0, update_stb pulses, no err.
    - Any other pattern: nibble i unchanged, digit_valid[i] <= 0, err <= 1, update_stb pulses.
- Other digits are never disturbed by a commit.
- err is sticky and cleared by err_clear on the next edge. If err_clear and a new error coincide in the same cycle, the error wins and err stays 1.
- A pattern that changes before reaching STABLE_CYCLES is discarded entirely; no output changes.
- A pattern held indefinitely commits once only. cnt saturates and does not wrap.
- STABLE_CYCLES=1: commit at E1 for every change in the sampled value.
- Pure RTL, no latches. Decode is a combinational case on the registered sample; commit is registered.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> digits_out=0, digit_valid=0, update_stb=0, err=0. Assert reset mid-episode after 2 stable cycles, release -> no commit until 3 fresh stable samples.
- Single digit (NUM_DIGITS=4, STABLE_CYCLES=3): segments_in=1011011, digit_sel=0010 held 10 cycles -> at E3 digits_out[7:4]=2, digit_valid=0010, update_stb high exactly one cycle, never again while held.
- Glitch rejection: 1111111 on sel 0001 for 2 cycles, then 1111101 held -> digit 0 becomes 6 three edges after the change. Value 8 never appears. Exactly one update_stb.
- Illegal/blank patterns: 1000000 on sel 0001 stable -> err=1, digit_valid[0]=0, nibble unchanged. Pulse err_clear together with a new illegal commit -> err stays 1. err_clear alone -> err=0 next cycle. Then 0000000 stable -> digit_valid[0]=0, err=0.
- Select faults: sel=0011 with 1111111 stable -> no digit change, err=1, no update_stb. sel=0000 stable -> no change, no strobe.
- Multiplexed sweep: A/0001, B/0010, C/0100, D/1000, each held 4 cycles -> digits_out=16'hDCBA, digit_valid=4'b1111, four update_stb pulses, err=0.
